// File: rtl/moving_average_mc.sv
// Per-channel power-of-two moving average over a tagged, interleaved sample stream.
// Two-cycle latency, one sample per cycle, no backpressure; a flush squashes work in flight.
module moving_average_mc #(
  parameter int CHANNELS = 4,
  parameter int MAX_LOG2 = 4,
  parameter int DATA_W   = 16,
  parameter bit SIGNED   = 1'b0,
  parameter bit ROUND    = 1'b1,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int K_W     = $clog2(MAX_LOG2 + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic [K_W-1:0]    log2_depth,
  input  logic              clear,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              out_full
);

  localparam int DEPTH = 1 << MAX_LOG2;
  localparam int ACC_W = DATA_W + MAX_LOG2;
  localparam int F_W   = MAX_LOG2 + 1;
  localparam int SUM_W = ACC_W + 1;

  logic [MAX_LOG2-1:0] wptr_q [CHANNELS];
  logic [MAX_LOG2-1:0] wptr_d [CHANNELS];
  logic [F_W-1:0]      fill_q [CHANNELS];
  logic [F_W-1:0]      fill_d [CHANNELS];
  logic [ACC_W-1:0]    acc_q  [CHANNELS];
  logic [ACC_W-1:0]    acc_d  [CHANNELS];
  logic [K_W-1:0]      cur_k_q, cur_k_d;

  logic [DATA_W-1:0]   hist_mem [CHANNELS][DEPTH];

  logic                s1_vld_q, s1_vld_d;
  logic [CH_W-1:0]     s1_ch_q, s1_ch_d;
  logic [DATA_W-1:0]   s1_sample_q, s1_sample_d;
  logic [DATA_W-1:0]   s1_old_q, s1_old_d;
  logic                s1_full_q, s1_full_d;

  logic                out_valid_q, out_valid_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_full_q, out_full_d;

  logic [K_W-1:0]      k_clamp;
  logic                flush;
  logic                accept;
  logic [F_W-1:0]      win_len;
  logic [F_W-1:0]      fill_inc;
  logic [MAX_LOG2-1:0] rd_addr;
  logic [DATA_W-1:0]   old_val;
  logic [ACC_W-1:0]    sample_ext, old_ext, acc_next;
  logic [SUM_W-1:0]    rnd_add, rnd_sum;

  always_comb begin
    k_clamp  = (int'(log2_depth) > MAX_LOG2) ? K_W'(MAX_LOG2) : log2_depth;
    flush    = clear || (k_clamp != cur_k_q);
    accept   = in_valid && (int'(in_ch) < CHANNELS) && !flush;
    win_len  = F_W'(1) << cur_k_q;
    // With a full-depth window the low bits of win_len are zero, so the read hits wptr itself.
    rd_addr  = wptr_q[in_ch] - win_len[MAX_LOG2-1:0];
    fill_inc = fill_q[in_ch] + F_W'(1);
    old_val  = (fill_q[in_ch] < win_len) ? '0 : hist_mem[in_ch][rd_addr];

    wptr_d  = wptr_q;
    fill_d  = fill_q;
    acc_d   = acc_q;
    cur_k_d = cur_k_q;

    s1_vld_d    = accept;
    s1_ch_d     = in_ch;
    s1_sample_d = in_data;
    s1_old_d    = old_val;
    s1_full_d   = (fill_inc >= win_len);

    if (accept) begin
      wptr_d[in_ch] = wptr_q[in_ch] + 1'b1;
      if (fill_q[in_ch] != F_W'(DEPTH)) fill_d[in_ch] = fill_inc;
    end

    if (SIGNED) begin
      sample_ext = {{MAX_LOG2{s1_sample_q[DATA_W-1]}}, s1_sample_q};
      old_ext    = {{MAX_LOG2{s1_old_q[DATA_W-1]}}, s1_old_q};
    end else begin
      sample_ext = {{MAX_LOG2{1'b0}}, s1_sample_q};
      old_ext    = {{MAX_LOG2{1'b0}}, s1_old_q};
    end
    acc_next = acc_q[s1_ch_q] + sample_ext - old_ext;
    rnd_add  = (ROUND && (cur_k_q != '0)) ? (SUM_W'(1) << (cur_k_q - 1'b1)) : '0;
    rnd_sum  = {SIGNED && acc_next[ACC_W-1], acc_next} + rnd_add;

    out_valid_d = s1_vld_q && !flush;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_full_d  = out_full_q;
    if (out_valid_d) begin
      acc_d[s1_ch_q] = acc_next;
      out_ch_d       = s1_ch_q;
      out_full_d     = s1_full_q;
      if (SIGNED) out_data_d = DATA_W'($signed(rnd_sum) >>> cur_k_q);
      else        out_data_d = DATA_W'(rnd_sum >> cur_k_q);
    end

    // History is left alone on flush; fill gating hides stale words.
    if (flush) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_d[c] = '0;
        fill_d[c] = '0;
        acc_d[c]  = '0;
      end
      cur_k_d = k_clamp;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) hist_mem[in_ch][wptr_q[in_ch]] <= in_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c] <= '0;
        fill_q[c] <= '0;
        acc_q[c]  <= '0;
      end
      cur_k_q     <= '0;
      s1_vld_q    <= 1'b0;
      s1_ch_q     <= '0;
      s1_sample_q <= '0;
      s1_old_q    <= '0;
      s1_full_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_full_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      acc_q       <= acc_d;
      cur_k_q     <= cur_k_d;
      s1_vld_q    <= s1_vld_d;
      s1_ch_q     <= s1_ch_d;
      s1_sample_q <= s1_sample_d;
      s1_old_q    <= s1_old_d;
      s1_full_q   <= s1_full_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_full_q  <= out_full_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_full  = out_full_q;

endmodule

// File: tb/tb_moving_average_mc.sv
// Bench for moving_average_mc: unsigned and signed instances share one stimulus stream,
// each checked against a window-sum model through its own expected-result queue.
module tb_moving_average_mc;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic [15:0] in_data;
  logic [2:0]  log2_depth;
  logic        clear;

  logic        out_valid_u, out_full_u, out_valid_s, out_full_s;
  logic [1:0]  out_ch_u, out_ch_s;
  logic [15:0] out_data_u, out_data_s;

  always #5 clk = ~clk;

  moving_average_mc u_dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .log2_depth(log2_depth), .clear(clear), .out_valid(out_valid_u), .out_ch(out_ch_u),
    .out_data(out_data_u), .out_full(out_full_u)
  );

  moving_average_mc #(.SIGNED(1'b1)) u_dut_s (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .log2_depth(log2_depth), .clear(clear), .out_valid(out_valid_s), .out_ch(out_ch_s),
    .out_data(out_data_s), .out_full(out_full_s)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  ch;
    logic [15:0] dat;
    logic        full;
  } exp_t;

  exp_t        exp_u[$];
  exp_t        exp_s[$];
  logic [15:0] mhist [4][$];
  int          model_k = 0;
  bit          last_acc = 1'b0;
  logic [2:0]  k_now = 3'd2;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] last_u_dat = '0;
  logic [15:0] last_s_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Sum of the last D samples since the flush (missing ones are zero), divided by D.
  function automatic logic [15:0] model_avg(input bit sgn, input int ch);
    longint      sum = 0;
    longint      q;
    logic [63:0] qb;
    logic [15:0] s;
    int          n = mhist[ch].size();
    int          d = 1 << model_k;
    for (int i = 0; i < d; i++) begin
      if (i < n) begin
        s = mhist[ch][n-1-i];
        if (sgn) sum += longint'($signed(s));
        else     sum += longint'(s);
      end
    end
    if (model_k > 0) sum += d / 2;
    q = sum / d;
    if (sum < 0 && (sum % d) != 0) q -= 1;
    qb = q;
    return qb[15:0];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) mhist[c].delete();
    exp_u.delete();
    exp_s.delete();
    model_k  = 0;
    last_acc = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [1:0] ch, input logic [15:0] dat,
                       input logic [2:0] k, input bit clr);
    int   kc;
    bit   flush;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v; in_ch = ch; in_data = dat; log2_depth = k; clear = clr;
    k_now = k;
    kc    = (k > 3'd4) ? 4 : int'(k);
    flush = clr || (kc != model_k);
    if (flush) begin
      for (int c = 0; c < 4; c++) mhist[c].delete();
      model_k = kc;
      if (last_acc) begin
        void'(exp_u.pop_back());
        void'(exp_s.pop_back());
      end
      last_acc = 1'b0;
    end else if (v) begin
      mhist[ch].push_back(dat);
      if (mhist[ch].size() > 16) void'(mhist[ch].pop_front());
      e.cyc  = cyc + 2;
      e.ch   = ch;
      e.full = (mhist[ch].size() >= (1 << model_k));
      e.dat  = model_avg(1'b0, int'(ch));
      exp_u.push_back(e);
      e.dat  = model_avg(1'b1, int'(ch));
      exp_s.push_back(e);
      last_acc = 1'b1;
    end else begin
      last_acc = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'd0, 16'd0, k_now, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      if (exp_u.size() > 0 && exp_u[0].cyc == cyc) begin
        e = exp_u.pop_front();
        check_eq("u_valid", out_valid_u, 1);
        if (out_valid_u) begin
          check_eq("u_ch", out_ch_u, e.ch);
          check_eq("u_data", out_data_u, e.dat);
          check_eq("u_full", out_full_u, e.full);
          last_u_dat = e.dat;
        end
      end else if (out_valid_u) begin
        check_eq("u_unexpected_valid", out_valid_u, 0);
      end
      if (exp_s.size() > 0 && exp_s[0].cyc == cyc) begin
        e = exp_s.pop_front();
        check_eq("s_valid", out_valid_s, 1);
        if (out_valid_s) begin
          check_eq("s_ch", out_ch_s, e.ch);
          check_eq("s_data", out_data_s, e.dat);
          check_eq("s_full", out_full_s, e.full);
          last_s_dat = e.dat;
        end
      end else if (out_valid_s) begin
        check_eq("s_unexpected_valid", out_valid_s, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0; log2_depth = 3'd2; clear = 1'b0;
    #12;
    check_eq("rst_out_valid", out_valid_u, 0);
    check_eq("rst_out_ch", out_ch_u, 0);
    check_eq("rst_out_data", out_data_u, 0);
    check_eq("rst_out_full", out_full_u, 0);
    check_eq("rst_out_valid_s", out_valid_s, 0);
    @(posedge clk);
    #1 nrst = 1'b1;

    // Settle flush, then ch0 ramp with D=4.
    idle(1);
    for (int i = 1; i <= 5; i++) drive(1'b1, 2'd0, 16'(4 * i), 3'd2, 1'b0);
    idle(3);

    // Clear, then ch0 ramp interleaved with ch1 constant.
    drive(1'b0, 2'd0, 16'd0, 3'd2, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'd0, 16'(4 * i), 3'd2, 1'b0);
      drive(1'b1, 2'd1, 16'd100, 3'd2, 1'b0);
    end
    drive(1'b1, 2'd0, 16'd20, 3'd2, 1'b0);
    idle(3);

    // D=2 with negative samples on ch2.
    idle(1);
    drive(1'b0, 2'd0, 16'd0, 3'd1, 1'b0);
    drive(1'b1, 2'd2, 16'hFFFD, 3'd1, 1'b0);
    drive(1'b1, 2'd2, 16'hFFFD, 3'd1, 1'b0);
    drive(1'b1, 2'd2, 16'd5, 3'd1, 1'b0);
    idle(3);

    // Full-depth window at max value, then wraparound; log2_depth 7 clamps without flushing.
    drive(1'b0, 2'd0, 16'd0, 3'd4, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b1, 2'd0, 16'hFFFF, (i >= 8) ? 3'd7 : 3'd4, 1'b0);
    drive(1'b1, 2'd0, 16'd0, 3'd7, 1'b0);
    idle(3);

    // Depth change with a sample in flight, then the same via clear.
    drive(1'b0, 2'd0, 16'd0, 3'd2, 1'b0);
    drive(1'b1, 2'd0, 16'd50, 3'd2, 1'b0);
    drive(1'b1, 2'd0, 16'd60, 3'd0, 1'b0);
    drive(1'b1, 2'd0, 16'd7, 3'd0, 1'b0);
    drive(1'b1, 2'd0, 16'd9, 3'd0, 1'b0);
    idle(3);
    drive(1'b1, 2'd1, 16'd5, 3'd0, 1'b0);
    drive(1'b1, 2'd1, 16'd6, 3'd0, 1'b1);
    drive(1'b1, 2'd1, 16'd7, 3'd0, 1'b0);
    drive(1'b1, 2'd1, 16'd9, 3'd0, 1'b0);
    idle(3);

    // Asynchronous reset while a result is on the output.
    drive(1'b0, 2'd0, 16'd0, 3'd2, 1'b0);
    drive(1'b1, 2'd3, 16'd1000, 3'd2, 1'b0);
    drive(1'b1, 2'd3, 16'd2000, 3'd2, 1'b0);
    @(posedge clk);
    #2 check_eq("pre_reset_valid", out_valid_u, 1);
    #1;
    in_valid = 1'b0;
    nrst = 1'b0;
    model_reset();
    #1;
    check_eq("async_reset_valid", out_valid_u, 0);
    check_eq("async_reset_valid_s", out_valid_s, 0);
    check_eq("async_reset_data", out_data_u, 0);
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
    idle(1);
    drive(1'b1, 2'd3, 16'd40, 3'd2, 1'b0);
    idle(4);

    check_eq("u_queue_drained", exp_u.size(), 0);
    check_eq("s_queue_drained", exp_s.size(), 0);
    check_eq("u_hold_data", out_data_u, last_u_dat);
    check_eq("s_hold_data", out_data_s, last_s_dat);
    check_eq("idle_valid", out_valid_u, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
